grf: RTL and testbench

GRF -- requirements
Module: grf

---
 rtl/grf.sv | 56 +++++
 tb/tb_grf.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/grf.sv
// General register file: 32 x 32-bit, r0 hard-wired to zero, two combinational read ports.
// Define GRF_BYPASS_EN to forward same-cycle write data onto a matching read port.
module grf (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [4:0]  A3,
    input  logic [31:0] WD,
    input  logic        WE,
    output logic [31:0] RD1,
    output logic [31:0] RD2
);

    logic [31:0] regs [0:31];
    logic        wr_live;

    // Reset wins over a write on the same edge; r0 is never loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0000_0000;
            end
        end else if (WE && (A3 != 5'd0)) begin
            regs[A3] <= WD;
        end
    end

    assign wr_live = WE && !reset && (A3 != 5'd0);

    always_comb begin
        RD1 = 32'h0000_0000;
        RD2 = 32'h0000_0000;
        if (A1 != 5'd0) begin
`ifdef GRF_BYPASS_EN
            RD1 = (wr_live && (A3 == A1)) ? WD : regs[A1];
`else
            RD1 = regs[A1];
`endif
        end
        if (A2 != 5'd0) begin
`ifdef GRF_BYPASS_EN
            RD2 = (wr_live && (A3 == A2)) ? WD : regs[A2];
`else
            RD2 = regs[A2];
`endif
        end
    end

`ifndef GRF_BYPASS_EN
    // Without forwarding the live-write qualifier has no reader.
    logic unused_wr_live;
    assign unused_wr_live = wr_live;
`endif

endmodule

// File: tb/tb_grf.sv
// Self-checking bench for grf: directed vectors plus a per-cycle comparison against a register-array model.
module tb_grf;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2, A3;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD1, RD2;

    int tests = 0;
    int fails = 0;

    logic [31:0] model [0:31];
    logic        model_valid = 1'b0;

    grf dut (
        .clk  (clk),
        .reset(reset),
        .A1   (A1),
        .A2   (A2),
        .A3   (A3),
        .WD   (WD),
        .WE   (WE),
        .RD1  (RD1),
        .RD2  (RD2)
    );

    always #5 clk = ~clk;

    // Model: registers as a plain array updated by the architectural write rules.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
            model_valid = 1'b1;
        end else if (WE && A3 != 5'd0) begin
            model[A3] = WD;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef GRF_BYPASS_EN
        if (WE && !reset && A3 == a) return WD;
`endif
        return model[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (A1=%0d A2=%0d A3=%0d WE=%b reset=%b)",
                     name, act, exp, A1, A2, A3, WE, reset);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic we, input logic [4:0] a3,
                         input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        reset = rst; WE = we; A3 = a3; WD = wd; A1 = a1; A2 = a2;
        #1;
    endtask

    logic [31:0] bypass_exp;
    logic [31:0] pat;

    initial begin
        reset = 1'b1; WE = 1'b0; A1 = 0; A2 = 0; A3 = 0; WD = 0;
        tick();
        tick();

        fork
            forever begin
                @(negedge clk);
                if (model_valid) begin
                    check("cyc_rd1", RD1, exp_rd(A1));
                    check("cyc_rd2", RD2, exp_rd(A2));
                end
            end
        join_none

        // Reset state
        drive(0, 0, 0, 0, 5, 31);
        check("rst_rd1_r5", RD1, 32'h0);
        check("rst_rd2_r31", RD2, 32'h0);

        // Basic write then read
        drive(0, 1, 8, 32'h1234_5678, 0, 0);
        tick();
        drive(0, 0, 0, 0, 8, 0);
        check("wr8_rd1", RD1, 32'h1234_5678);

        // r0 is immutable
        drive(0, 1, 0, 32'hFFFF_FFFF, 0, 0);
        check("r0_during_wr_rd1", RD1, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("r0_after_wr_rd1", RD1, 32'h0);
        check("r0_after_wr_rd2", RD2, 32'h0);

        // Same-cycle read of the register being written
`ifdef GRF_BYPASS_EN
        bypass_exp = 32'hABCD_0000;
`else
        bypass_exp = 32'h0;
`endif
        drive(0, 1, 9, 32'hABCD_0000, 9, 8);
        check("rdw9_before_edge", RD1, bypass_exp);
        check("rdw_other_port", RD2, 32'h1234_5678);
        tick();
        drive(0, 0, 0, 0, 9, 9);
        check("rdw9_after_edge", RD1, 32'hABCD_0000);
        check("a1_eq_a2_rd2", RD2, 32'hABCD_0000);

        // Reset beats a concurrent write and clears prior writes
        drive(0, 1, 3, 32'h11, 3, 0);
        tick();
        drive(1, 1, 3, 32'h22, 3, 8);
        tick();
        drive(0, 0, 0, 0, 3, 8);
        check("rst_prio_r3", RD1, 32'h0);
        check("rst_clear_r8", RD2, 32'h0);

        // WE=0 leaves storage alone
        drive(0, 1, 4, 32'h44, 0, 0);
        tick();
        drive(0, 0, 4, 32'h55, 4, 4);
        tick();
        check("we0_r4_rd1", RD1, 32'h44);
        check("we0_r4_rd2", RD2, 32'h44);

        // Fill every register with a distinct pattern, read them all back
        for (int i = 0; i < 32; i++) begin
            drive(0, 1, 5'(i), 32'hA500_0000 | (32'(i) * 32'h0001_0101), 0, 0);
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 0, 5'(i), 5'(31 - i));
            pat = (i == 0) ? 32'h0 : (32'hA500_0000 | (32'(i) * 32'h0001_0101));
            check("fill_rd1", RD1, pat);
            tick();
        end

        // Write and read of different registers do not interact
        drive(0, 1, 10, 32'h0000_0001, 11, 12);
        check("indep_r11", RD1, 32'hA500_0000 | (32'd11 * 32'h0001_0101));
        tick();

        // Random traffic, checked every cycle by the compare process
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), $urandom(),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) A1 = A3;
            if ($urandom_range(0, 3) == 0) A2 = A3;
            tick();
        end

        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
